// File: rtl/rob_multi_cdb_if.sv
// Bus bundle for rob_multi_cdb: allocate, completion (CDB), commit, flush and
// occupancy signals. The exception ports exist only when ROB_EXC_EN is defined.
interface rob_multi_cdb_if #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned RD_W    = 5,
    parameter int unsigned NUM_CDB = 2
);
    localparam int unsigned TAG_W = $clog2(DEPTH);

    logic                        alloc_valid;
    logic                        alloc_ready;
    logic [PC_W-1:0]             alloc_pc;
    logic [RD_W-1:0]             alloc_rd;
    logic [TAG_W-1:0]            alloc_tag;
    logic [NUM_CDB-1:0]          cdb_valid;
    logic [NUM_CDB*TAG_W-1:0]    cdb_tag;
    logic [NUM_CDB*DATA_W-1:0]   cdb_data;
    logic                        commit_valid;
    logic                        commit_ready;
    logic [TAG_W-1:0]            commit_tag;
    logic [RD_W-1:0]             commit_rd;
    logic [PC_W-1:0]             commit_pc;
    logic [DATA_W-1:0]           commit_data;
    logic                        flush;
    logic [TAG_W:0]              count;
    logic                        empty;
    logic                        full;
`ifdef ROB_EXC_EN
    logic [NUM_CDB-1:0]          cdb_exc;
    logic                        commit_exc;

    modport master (
        output alloc_valid, alloc_pc, alloc_rd, cdb_valid, cdb_tag, cdb_data,
               commit_ready, flush, cdb_exc,
        input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd,
               commit_pc, commit_data, count, empty, full, commit_exc
    );
    modport slave (
        input  alloc_valid, alloc_pc, alloc_rd, cdb_valid, cdb_tag, cdb_data,
               commit_ready, flush, cdb_exc,
        output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd,
               commit_pc, commit_data, count, empty, full, commit_exc
    );
`else
    modport master (
        output alloc_valid, alloc_pc, alloc_rd, cdb_valid, cdb_tag, cdb_data,
               commit_ready, flush,
        input  alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd,
               commit_pc, commit_data, count, empty, full
    );
    modport slave (
        input  alloc_valid, alloc_pc, alloc_rd, cdb_valid, cdb_tag, cdb_data,
               commit_ready, flush,
        output alloc_ready, alloc_tag, commit_valid, commit_tag, commit_rd,
               commit_pc, commit_data, count, empty, full
    );
`endif
endinterface

// File: rtl/rob_multi_cdb.sv
// Circular reorder buffer: in-order allocate, out-of-order completion on
// NUM_CDB result buses, in-order retire, single-cycle flush.
// Optional feature macro: ROB_EXC_EN (per-entry exception bit; retiring an
// excepting head empties the ROB exactly like a flush).
module rob_multi_cdb #(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PC_W    = 32,
    parameter int unsigned RD_W    = 5,
    parameter int unsigned NUM_CDB = 2
) (
    input  logic             clk,
    input  logic             rst,
    rob_multi_cdb_if.slave   bus
);
    localparam int unsigned TAG_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = TAG_W + 1;

    // Pointers carry a wrap bit above the index
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [TAG_W-1:0]  head_idx;
    logic [TAG_W-1:0]  tail_idx;

    logic [DEPTH-1:0]  ent_valid;
    logic [DEPTH-1:0]  ent_done;
    logic [PC_W-1:0]   ent_pc   [DEPTH];
    logic [RD_W-1:0]   ent_rd   [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];

    logic [DEPTH-1:0]  cmp_hit;
    logic [DEPTH-1:0]  cmp_take;
    logic [DATA_W-1:0] cmp_data [DEPTH];

    logic empty;
    logic full;
    logic commit_valid;
    logic alloc_fire;
    logic retire;
    logic clear;

`ifdef ROB_EXC_EN
    logic [DEPTH-1:0]  ent_exc;
    logic [DEPTH-1:0]  cmp_exc;
`endif

    assign head_idx = head[TAG_W-1:0];
    assign tail_idx = tail[TAG_W-1:0];

    assign empty = (head == tail);
    assign full  = (head_idx == tail_idx) && (head[TAG_W] != tail[TAG_W]);

    assign commit_valid = !empty && ent_valid[head_idx] && ent_done[head_idx];
    assign alloc_fire   = bus.alloc_valid && !full;
    assign retire       = commit_valid && bus.commit_ready;

`ifdef ROB_EXC_EN
    assign clear = bus.flush || (retire && ent_exc[head_idx]);
`else
    assign clear = bus.flush;
`endif

    // Route completions to entries; iterating high-to-low lets the lowest channel win a tag collision
    always_comb begin
        cmp_hit = '0;
`ifdef ROB_EXC_EN
        cmp_exc = '0;
`endif
        for (int e = 0; e < int'(DEPTH); e++) begin
            cmp_data[e] = '0;
        end
        for (int i = int'(NUM_CDB) - 1; i >= 0; i--) begin
            if (bus.cdb_valid[i]) begin
                cmp_hit[bus.cdb_tag[i*TAG_W +: TAG_W]]  = 1'b1;
                cmp_data[bus.cdb_tag[i*TAG_W +: TAG_W]] = bus.cdb_data[i*DATA_W +: DATA_W];
`ifdef ROB_EXC_EN
                cmp_exc[bus.cdb_tag[i*TAG_W +: TAG_W]]  = bus.cdb_exc[i];
`endif
            end
        end
        // Stale, already-done and not-yet-allocated targets are dropped here
        cmp_take = cmp_hit & ent_valid & ~ent_done;
    end

    // Pointer and entry status update; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head      <= '0;
            tail      <= '0;
            ent_valid <= '0;
            ent_done  <= '0;
`ifdef ROB_EXC_EN
            ent_exc   <= '0;
`endif
        end else begin
            for (int e = 0; e < int'(DEPTH); e++) begin
                if (cmp_take[e]) begin
                    ent_done[e] <= 1'b1;
`ifdef ROB_EXC_EN
                    ent_exc[e]  <= cmp_exc[e];
`endif
                end
            end
            if (retire) begin
                ent_valid[head_idx] <= 1'b0;
                ent_done[head_idx]  <= 1'b0;
                head                <= head + PTR_W'(1);
            end
            if (alloc_fire) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
`ifdef ROB_EXC_EN
                ent_exc[tail_idx]   <= 1'b0;
`endif
                tail                <= tail + PTR_W'(1);
            end
        end
    end

    // Payload storage; only meaningful while the matching valid bit is set
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_pc[tail_idx] <= bus.alloc_pc;
            ent_rd[tail_idx] <= bus.alloc_rd;
        end
        for (int e = 0; e < int'(DEPTH); e++) begin
            if (cmp_take[e]) begin
                ent_data[e] <= cmp_data[e];
            end
        end
    end

    assign bus.alloc_ready  = !full;
    assign bus.alloc_tag    = tail_idx;
    assign bus.count        = tail - head;
    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.commit_valid = commit_valid;
    assign bus.commit_tag   = commit_valid ? head_idx           : '0;
    assign bus.commit_rd    = commit_valid ? ent_rd[head_idx]   : '0;
    assign bus.commit_pc    = commit_valid ? ent_pc[head_idx]   : '0;
    assign bus.commit_data  = commit_valid ? ent_data[head_idx] : '0;
`ifdef ROB_EXC_EN
    assign bus.commit_exc   = commit_valid && ent_exc[head_idx];
`endif

endmodule

// File: tb/tb_rob_multi_cdb.sv
// Directed bench for rob_multi_cdb: a per-cycle vector table for completion,
// collision and flush behaviour, plus sequences for fill/full, full-commit
// and pointer wrap.
module tb_rob_multi_cdb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    rob_multi_cdb_if bus ();

    rob_multi_cdb dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Inputs for one cycle, then the outputs expected before that cycle's edge
    typedef struct {
        logic [31:0] av, pc, rd, cv, t0, d0, t1, d1, cr, fl;
        logic [31:0] e_ar, e_at, e_cv, e_ct, e_crd, e_cpc, e_cd, e_cnt, e_emp, e_full;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alloc_valid  = 1'b0;
        bus.alloc_pc     = '0;
        bus.alloc_rd     = '0;
        bus.cdb_valid    = '0;
        bus.cdb_tag      = '0;
        bus.cdb_data     = '0;
        bus.commit_ready = 1'b0;
        bus.flush        = 1'b0;
`ifdef ROB_EXC_EN
        bus.cdb_exc      = '0;
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        vecs[0]  = '{0,0,0,         0,0,0,0,0,             0,0, 1,0,0,0,0,0,0,          0,1,0};
        vecs[1]  = '{1,'h100,1,     0,0,0,0,0,             0,0, 1,0,0,0,0,0,0,          0,1,0};
        vecs[2]  = '{1,'h104,2,     0,0,0,0,0,             0,0, 1,1,0,0,0,0,0,          1,0,0};
        vecs[3]  = '{1,'h108,3,     0,0,0,0,0,             0,0, 1,2,0,0,0,0,0,          2,0,0};
        vecs[4]  = '{0,0,0,         3,2,'h22C,0,'hA,       0,0, 1,3,0,0,0,0,0,          3,0,0};
        vecs[5]  = '{0,0,0,         0,0,0,0,0,             1,0, 1,3,1,0,1,'h100,'hA,    3,0,0};
        vecs[6]  = '{0,0,0,         0,0,0,0,0,             1,0, 1,3,0,0,0,0,0,          2,0,0};
        vecs[7]  = '{0,0,0,         2,0,0,1,'h55,          1,0, 1,3,0,0,0,0,0,          2,0,0};
        vecs[8]  = '{0,0,0,         0,0,0,0,0,             1,0, 1,3,1,1,2,'h104,'h55,   2,0,0};
        vecs[9]  = '{0,0,0,         0,0,0,0,0,             0,0, 1,3,1,2,3,'h108,'h22C,  1,0,0};
        vecs[10] = '{0,0,0,         0,0,0,0,0,             1,0, 1,3,1,2,3,'h108,'h22C,  1,0,0};
        vecs[11] = '{1,'h10C,4,     1,3,'h99,0,0,          0,0, 1,3,0,0,0,0,0,          0,1,0};
        vecs[12] = '{0,0,0,         3,3,'h11,3,'h22,       0,0, 1,4,0,0,0,0,0,          1,0,0};
        vecs[13] = '{0,0,0,         1,3,'h33,0,0,          0,0, 1,4,1,3,4,'h10C,'h11,   1,0,0};
        vecs[14] = '{0,0,0,         0,0,0,0,0,             0,0, 1,4,1,3,4,'h10C,'h11,   1,0,0};
        vecs[15] = '{1,'h110,5,     0,0,0,0,0,             0,0, 1,4,1,3,4,'h10C,'h11,   1,0,0};
        vecs[16] = '{1,'h114,6,     0,0,0,0,0,             0,0, 1,5,1,3,4,'h10C,'h11,   2,0,0};
        vecs[17] = '{1,'h118,7,     0,0,0,0,0,             0,0, 1,6,1,3,4,'h10C,'h11,   3,0,0};
        vecs[18] = '{1,'h11C,8,     0,0,0,0,0,             0,0, 1,7,1,3,4,'h10C,'h11,   4,0,0};
        vecs[19] = '{1,'h200,9,     1,4,'h44,0,0,          1,1, 1,8,1,3,4,'h10C,'h11,   5,0,0};
        vecs[20] = '{0,0,0,         0,0,0,0,0,             0,0, 1,0,0,0,0,0,0,          0,1,0};
        vecs[21] = '{1,'h300,1,     0,0,0,0,0,             0,0, 1,0,0,0,0,0,0,          0,1,0};
        vecs[22] = '{0,0,0,         0,0,0,0,0,             0,0, 1,1,0,0,0,0,0,          1,0,0};

        do_reset();

        // Table: completion ordering, tag collision, stale completion, flush
        foreach (vecs[k]) begin
            @(negedge clk);
            bus.alloc_valid  = 1'(vecs[k].av);
            bus.alloc_pc     = 32'(vecs[k].pc);
            bus.alloc_rd     = 5'(vecs[k].rd);
            bus.cdb_valid    = 2'(vecs[k].cv);
            bus.cdb_tag      = {4'(vecs[k].t1), 4'(vecs[k].t0)};
            bus.cdb_data     = {32'(vecs[k].d1), 32'(vecs[k].d0)};
            bus.commit_ready = 1'(vecs[k].cr);
            bus.flush        = 1'(vecs[k].fl);
            #1;
            check($sformatf("v%0d alloc_ready", k),  64'(bus.alloc_ready),  64'(vecs[k].e_ar));
            check($sformatf("v%0d alloc_tag", k),    64'(bus.alloc_tag),    64'(vecs[k].e_at));
            check($sformatf("v%0d commit_valid", k), 64'(bus.commit_valid), 64'(vecs[k].e_cv));
            check($sformatf("v%0d commit_tag", k),   64'(bus.commit_tag),   64'(vecs[k].e_ct));
            check($sformatf("v%0d commit_rd", k),    64'(bus.commit_rd),    64'(vecs[k].e_crd));
            check($sformatf("v%0d commit_pc", k),    64'(bus.commit_pc),    64'(vecs[k].e_cpc));
            check($sformatf("v%0d commit_data", k),  64'(bus.commit_data),  64'(vecs[k].e_cd));
            check($sformatf("v%0d count", k),        64'(bus.count),        64'(vecs[k].e_cnt));
            check($sformatf("v%0d empty", k),        64'(bus.empty),        64'(vecs[k].e_emp));
            check($sformatf("v%0d full", k),         64'(bus.full),         64'(vecs[k].e_full));
        end

        // Fill to full from reset
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            idle_inputs();
            bus.alloc_valid = 1'b1;
            bus.alloc_pc    = 32'('h400 + 4 * i);
            #1;
            check($sformatf("fill alloc_tag %0d", i), 64'(bus.alloc_tag), 64'(i));
            check($sformatf("fill alloc_ready %0d", i), 64'(bus.alloc_ready), 64'(1));
        end
        @(negedge clk);
        idle_inputs();
        #1;
        check("fill full", 64'(bus.full), 64'(1));
        check("fill alloc_ready", 64'(bus.alloc_ready), 64'(0));
        check("fill count", 64'(bus.count), 64'(16));
        check("fill empty", 64'(bus.empty), 64'(0));

        // Full ROB: complete head, then commit and alloc together
        bus.cdb_valid = 2'b01;
        bus.cdb_tag   = {4'd0, 4'd0};
        bus.cdb_data  = {32'd0, 32'h77};
        @(negedge clk);
        idle_inputs();
        bus.alloc_valid  = 1'b1;
        bus.alloc_pc     = 32'hABC;
        bus.commit_ready = 1'b1;
        #1;
        check("fullc commit_valid", 64'(bus.commit_valid), 64'(1));
        check("fullc commit_tag", 64'(bus.commit_tag), 64'(0));
        check("fullc commit_data", 64'(bus.commit_data), 64'h77);
        check("fullc commit_pc", 64'(bus.commit_pc), 64'h400);
        check("fullc alloc_ready", 64'(bus.alloc_ready), 64'(0));
        @(negedge clk);
        bus.commit_ready = 1'b0;
        #1;
        check("fullc count after", 64'(bus.count), 64'(15));
        check("fullc full after", 64'(bus.full), 64'(0));
        check("fullc alloc_ready after", 64'(bus.alloc_ready), 64'(1));
        check("fullc alloc_tag reuse", 64'(bus.alloc_tag), 64'(0));
        @(negedge clk);
        idle_inputs();
        #1;
        check("fullc refill count", 64'(bus.count), 64'(16));
        check("fullc refill full", 64'(bus.full), 64'(1));
        check("fullc head blocked", 64'(bus.commit_valid), 64'(0));

        // Streaming wrap: 40 instructions through 16 entries
        do_reset();
        begin
            int ncommit = 0;
            int occ     = 0;
            for (int c = 0; c < 200 && ncommit < 40; c++) begin
                @(negedge clk);
                idle_inputs();
                bus.commit_ready = 1'b1;
                if (c < 40) begin
                    bus.alloc_valid = 1'b1;
                    bus.alloc_pc    = 32'('h1000 + 4 * c);
                    bus.alloc_rd    = 5'(c % 32);
                end
                if (c >= 1 && c <= 40) begin
                    if (c % 2 == 0) begin
                        bus.cdb_valid = 2'b01;
                        bus.cdb_tag   = {4'd0, 4'((c - 1) % 16)};
                        bus.cdb_data  = {32'd0, 32'((c - 1) * 3 + 1)};
                    end else begin
                        bus.cdb_valid = 2'b10;
                        bus.cdb_tag   = {4'((c - 1) % 16), 4'd0};
                        bus.cdb_data  = {32'((c - 1) * 3 + 1), 32'd0};
                    end
                end
                #1;
                check($sformatf("wrap count c%0d", c), 64'(bus.count), 64'(occ));
                check($sformatf("wrap empty c%0d", c), 64'(bus.empty), 64'(occ == 0));
                check($sformatf("wrap full c%0d", c), 64'(bus.full), 64'(0));
                if (c < 40) begin
                    check($sformatf("wrap alloc_tag c%0d", c), 64'(bus.alloc_tag), 64'(c % 16));
                    occ++;
                end
                if (bus.commit_valid) begin
                    check($sformatf("wrap commit_tag n%0d", ncommit), 64'(bus.commit_tag), 64'(ncommit % 16));
                    check($sformatf("wrap commit_pc n%0d", ncommit), 64'(bus.commit_pc), 64'('h1000 + 4 * ncommit));
                    check($sformatf("wrap commit_data n%0d", ncommit), 64'(bus.commit_data), 64'(ncommit * 3 + 1));
                    ncommit++;
                    occ--;
                end
            end
            check("wrap commits", 64'(ncommit), 64'(40));
            @(negedge clk);
            idle_inputs();
            #1;
            check("wrap final empty", 64'(bus.empty), 64'(1));
            check("wrap final alloc_tag", 64'(bus.alloc_tag), 64'(40 % 16));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
